// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller with 256-bit block refill/write-back.
// Optional hit/miss counters are built only when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
    parameter int LINES = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         p1_req_i,
    input  logic         p1_wr_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_data_i,
    output logic [31:0]  p1_data_o,
    output logic         p1_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = 32 - 5 - INDEX_W;

    // state | meaning: IDLE lookup/hit service, WRITEBACK dirty victim out, REFILL block in
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_RF   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [255:0]       data_q [LINES];

    logic [2:0]         word;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               in_idle;
    logic               hit;
    logic               miss;
    logic               store_hit;
    logic               wb_done;
    logic               rf_done;
    logic               unused_addr_bits;

    assign word    = p1_addr_i[4:2];
    assign idx     = p1_addr_i[5+INDEX_W-1:5];
    assign tag     = p1_addr_i[31:5+INDEX_W];
    assign unused_addr_bits = ^p1_addr_i[1:0];

    assign in_idle   = (state_q == ST_IDLE);
    assign hit       = p1_req_i & valid_q[idx] & (tag_q[idx] == tag);
    assign miss      = in_idle & p1_req_i & ~hit & ~rst_i;
    assign store_hit = in_idle & hit & p1_wr_i & ~rst_i;
    assign wb_done   = (state_q == ST_WB) & mem_ack_i;
    assign rf_done   = (state_q == ST_RF) & mem_ack_i;

    assign p1_stall_o = ~rst_i & (~in_idle | (p1_req_i & ~hit));
    assign p1_data_o  = (~rst_i & in_idle & hit & ~p1_wr_i) ? data_q[idx][{word, 5'b0} +: 32] : 32'd0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (miss) state_d = (valid_q[idx] & dirty_q[idx]) ? ST_WB : ST_RF;
            ST_WB:   if (mem_ack_i) state_d = ST_RF;
            ST_RF:   if (mem_ack_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'd0;
        mem_data_o   = 256'd0;
        if (!rst_i) begin
            if (state_q == ST_WB) begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[idx], idx, 5'b0};
                mem_data_o   = data_q[idx];
            end else if (state_q == ST_RF) begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, idx, 5'b0};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (wb_done) dirty_q[idx] <= 1'b0;
            if (rf_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
            if (store_hit) dirty_q[idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone make them meaningful.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (rf_done) begin
                data_q[idx] <= mem_data_i;
                tag_q[idx]  <= tag;
            end else if (store_hit) begin
                data_q[idx][{word, 5'b0} +: 32] <= p1_data_i;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            if (in_idle & hit) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = 32'd0;
    assign miss_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: word-level reference memory, small tag model and a latency-programmable memory responder.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         p1_req_i;
    logic         p1_wr_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    always #5 clk_i = ~clk_i;

    dcache_ctrl #(.LINES(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p1_req_i(p1_req_i), .p1_wr_i(p1_wr_i), .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
        .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    bit          mv [32];
    bit          md [32];
    logic [21:0] mt [32];

    logic [255:0] bmem    [logic [31:0]];
    logic [31:0]  ref_mem [logic [31:0]];
    logic [31:0]  exp_q   [$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3C3, ~a[15:0]};
    endfunction

    function automatic logic [255:0] mem_block(input logic [31:0] base);
        logic [255:0] blk;
        if (bmem.exists(base)) return bmem[base];
        for (int w = 0; w < 8; w++) blk[w*32 +: 32] = pat(base + 32'(w * 4));
        return blk;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return pat(a);
    endfunction

    function automatic logic [255:0] ref_block(input logic [31:0] base);
        logic [255:0] blk;
        for (int w = 0; w < 8; w++) blk[w*32 +: 32] = ref_word(base + 32'(w * 4));
        return blk;
    endfunction

    task automatic check_cnt(input string tag);
        check({tag, " hit_cnt"},  hit_cnt_o,  STATS ? 32'(exp_hits)   : 32'd0);
        check({tag, " miss_cnt"}, miss_cnt_o, STATS ? 32'(exp_misses) : 32'd0);
    endtask

    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input string tag);
        logic [31:0]  a;
        logic [4:0]   idx;
        logic [21:0]  t;
        bit           miss, dmiss, done, wb_seen, rf_seen;
        int           exp_stall, nstall, wcnt;
        logic [31:0]  wb_addr, rf_addr, exp_wb_addr;
        logic [255:0] wb_data, exp_wb_data;

        a   = {addr[31:2], 2'b00};
        idx = addr[9:5];
        t   = addr[31:10];
        miss  = !mv[idx] || (mt[idx] != t);
        dmiss = miss && mv[idx] && md[idx];
        exp_wb_addr = {mt[idx], idx, 5'b0};
        exp_wb_data = ref_block(exp_wb_addr);
        exp_stall = miss ? (2 + waits + (dmiss ? 1 + waits : 0)) : 0;
        mv[idx] = 1'b1;
        mt[idx] = t;
        md[idx] = wr ? 1'b1 : (miss ? 1'b0 : md[idx]);
        exp_hits++;
        if (miss) exp_misses++;
        if (!wr) exp_q.push_back(ref_word(a));
        else ref_mem[a] = wdata;

        p1_req_i = 1'b1; p1_wr_i = wr; p1_addr_i = addr; p1_data_i = wdata;
        nstall = 0; wcnt = 0; done = 0; wb_seen = 0; rf_seen = 0;
        wb_addr = '0; rf_addr = '0; wb_data = '0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk_i);
            if (!p1_stall_o) begin
                done = 1;
                if (!wr) check({tag, " rdata"}, p1_data_o, exp_q.pop_front());
            end else begin
                nstall++;
                if (mem_enable_o) begin
                    if (wcnt == waits) begin
                        mem_ack_i = 1'b1;
                        if (mem_write_o) begin
                            wb_seen = 1; wb_addr = mem_addr_o; wb_data = mem_data_o;
                            bmem[mem_addr_o] = mem_data_o;
                        end else begin
                            rf_seen = 1; rf_addr = mem_addr_o;
                            mem_data_i = mem_block(mem_addr_o);
                        end
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end
                @(posedge clk_i);
                #1 mem_ack_i = 1'b0;
            end
        end
        if (!done) check({tag, " timeout"}, 256'd0, 256'd1);
        @(posedge clk_i);
        #1 p1_req_i = 1'b0; p1_wr_i = 1'b0;

        check({tag, " stall_cycles"}, 256'(nstall), 256'(exp_stall));
        check({tag, " wb_seen"}, 256'(wb_seen), 256'(dmiss));
        check({tag, " rf_seen"}, 256'(rf_seen), 256'(miss));
        if (dmiss) begin
            check({tag, " wb_addr"}, wb_addr, exp_wb_addr);
            check({tag, " wb_data"}, wb_data, exp_wb_data);
        end
        if (miss) check({tag, " rf_addr"}, rf_addr, {addr[31:5], 5'b0});
        check_cnt(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] blk;
        bit           seen;

        mem_ack_i = 1'b0; mem_data_i = '0;
        p1_req_i = 1'b1; p1_wr_i = 1'b0; p1_addr_i = 32'h44; p1_data_i = '0;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset stall", p1_stall_o, 1'b0);
        check("reset mem_enable", mem_enable_o, 1'b0);
        check("reset p1_data", p1_data_o, 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0; p1_req_i = 1'b0;
        @(negedge clk_i);
        check("idle stall", p1_stall_o, 1'b0);
        check_cnt("reset");

        blk = mem_block(32'h40);
        blk[63:32] = 32'hDEAD_BEEF;
        bmem[32'h40] = blk;
        ref_mem[32'h44] = 32'hDEAD_BEEF;

        @(posedge clk_i); #1;
        access(0, 32'h0000_0044, 32'h0, 3, "cold_load");
        access(1, 32'h0000_0044, 32'h1234_5678, 0, "store_hit");
        access(0, 32'h0000_0044, 32'h0, 0, "load_hit");
        access(0, 32'h0000_0444, 32'h0, 1, "conflict_load");
        access(1, 32'h0000_0088, 32'hA5A5_A5A5, 0, "store_miss");
        access(0, 32'h0000_0088, 32'h0, 0, "load_88");
        access(0, 32'h0000_0488, 32'h0, 2, "evict_line4");

        // reset while a refill has its ack pending
        p1_req_i = 1'b1; p1_wr_i = 1'b0; p1_addr_i = 32'h0000_0100;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk_i);
            if (mem_enable_o) seen = 1;
        end
        check("rst_mid enable_seen", 256'(seen), 256'd1);
        mem_ack_i = 1'b1; mem_data_i = {8{32'hBAD0_BAD0}}; rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0; mem_ack_i = 1'b0; p1_req_i = 1'b0;
        for (int i = 0; i < 32; i++) begin mv[i] = 0; md[i] = 0; end
        exp_hits = 0; exp_misses = 0;
        @(negedge clk_i);
        check("rst_mid stall", p1_stall_o, 1'b0);
        check("rst_mid mem_enable", mem_enable_o, 1'b0);
        check_cnt("rst_mid");
        @(posedge clk_i); #1;
        access(0, 32'h0000_0100, 32'h0, 2, "after_rst_load");

        // spurious ack with no request
        @(negedge clk_i);
        mem_ack_i = 1'b1; mem_data_i = {8{32'h0BAD_F00D}};
        @(posedge clk_i);
        #1 mem_ack_i = 1'b0;
        @(negedge clk_i);
        check("spur stall", p1_stall_o, 1'b0);
        check("spur mem_enable", mem_enable_o, 1'b0);
        check("spur p1_data", p1_data_o, 32'd0);
        check_cnt("spur");
        @(posedge clk_i); #1;
        access(0, 32'h0000_0100, 32'h0, 0, "spur_reload");

        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra;
            ra = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5) |
                 (32'($urandom_range(0, 7)) << 2);
            access(1'($urandom_range(0, 1)), ra, $urandom, int'($urandom_range(0, 3)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
